// File: rtl/clock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared definitions for the digital-clock time/mode controller:
//   - state_t      : controller mode, encoded exactly as driven on the mode port
//   - HR_MAX       : last valid BCD hour before wrapping to 00
//   - MIN_SEC_MAX  : last valid BCD minute/second before wrapping to 00
//   - bcd_inc()    : two-digit BCD +1 without any wrap check
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    localparam logic [7:0] HR_MAX      = 8'h23;
    localparam logic [7:0] MIN_SEC_MAX = 8'h59;

    // Low digit 9 rolls to 0 and carries into the high digit. Callers handle
    // the field wrap, so the high digit never has to roll past 5 here.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter that counts 00..MAX and wraps back to 00.
// Ports:
//   clk_in    in   system clock
//   reset_n   in   synchronous active-low reset, loads RESET_VAL
//   inc       in   advance by one (wraps MAX -> 00)
//   clr       in   force count to 00
//   load      in   force count to load_val
//   load_val  in   value taken when load is high
//   count     out  registered BCD count
//   wrap      out  combinational: inc is being applied while count == MAX
// Priority: reset > load > clr > inc.
// -----------------------------------------------------------------------------
module bcd_mod_counter
    import clock_ctrl_pkg::*;
#(
    parameter logic [7:0] MAX       = 8'h59,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       wrap
);

    logic at_max;

    assign at_max = (count == MAX);

    // Only report a wrap when the increment actually takes effect, so the next
    // stage never carries on a cycle where clr/load override the count.
    assign wrap = inc && !clr && !load && at_max;

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (clr) begin
            count <= 8'h00;
        end else if (inc) begin
            count <= at_max ? 8'h00 : bcd_inc(count);
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Mode and time-keeping controller for the digital clock. Counts BCD
// hh:mm:ss from the 1 Hz tick in RUN, and lets the user edit hours and
// minutes with two debounced buttons.
// Ports:
//   clk_in    in   system clock
//   reset_n   in   synchronous active-low reset
//   tick      in   one-cycle pulse, nominally 1 Hz
//   btn_mode  in   debounced level; rising edge steps RUN -> SET_HR -> SET_MIN
//   btn_inc   in   debounced level; rising edge increments the edited field
//   hr_bcd    out  hours, BCD 00..23
//   min_bcd   out  minutes, BCD 00..59
//   sec_bcd   out  seconds, BCD 00..59
//   mode      out  00 RUN, 01 SET_HR, 10 SET_MIN
//   blink     out  blank-phase flag for the field being edited
// -----------------------------------------------------------------------------
module time_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter logic [7:0] RESET_HR  = 8'h12,
    parameter logic [7:0] RESET_MIN = 8'h00
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       blink
);

    state_t state;
    state_t state_next;
    logic   blink_next;

    logic   mode_q;
    logic   inc_q;
    logic   mode_edge;
    logic   inc_edge;

    logic   in_run;
    logic   sec_inc;
    logic   sec_clr;
    logic   min_inc;
    logic   hr_inc;
    logic   sec_wrap;
    logic   min_wrap;
    logic   hr_wrap;

    assign mode_edge = btn_mode & ~mode_q;
    assign inc_edge  = btn_inc & ~inc_q;

    assign in_run = (state == RUN);

    // Counter control. In RUN the tick ripples through the wrap pulses so all
    // three fields update on the same edge. In the set states a mode edge
    // beats an inc edge, and editing minutes never carries into hours.
    assign sec_inc = in_run & tick;
    assign sec_clr = (state == SET_MIN) & mode_edge;
    assign min_inc = in_run ? sec_wrap : ((state == SET_MIN) & inc_edge & ~mode_edge);
    assign hr_inc  = in_run ? min_wrap : ((state == SET_HR) & inc_edge & ~mode_edge);

    bcd_mod_counter #(
        .MAX       (MIN_SEC_MAX),
        .RESET_VAL (8'h00)
    ) u_sec (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .inc      (sec_inc),
        .clr      (sec_clr),
        .load     (1'b0),
        .load_val (8'h00),
        .count    (sec_bcd),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(
        .MAX       (MIN_SEC_MAX),
        .RESET_VAL (RESET_MIN)
    ) u_min (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .inc      (min_inc),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (8'h00),
        .count    (min_bcd),
        .wrap     (min_wrap)
    );

    // Hours wrap 23 -> 00 with nothing further to carry into.
    bcd_mod_counter #(
        .MAX       (HR_MAX),
        .RESET_VAL (RESET_HR)
    ) u_hr (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .inc      (hr_inc),
        .clr      (1'b0),
        .load     (1'b0),
        .load_val (8'h00),
        .count    (hr_bcd),
        .wrap     (hr_wrap)
    );

    // Next mode and blink. Entering any state clears blink; while editing,
    // each tick flips it. The unused 2'b11 encoding falls back to RUN.
    always_comb begin
        state_next = state;
        blink_next = 1'b0;
        case (state)
            RUN: begin
                if (mode_edge) begin
                    state_next = SET_HR;
                end
            end
            SET_HR: begin
                if (mode_edge) begin
                    state_next = SET_MIN;
                end else if (tick) begin
                    blink_next = ~blink;
                end else begin
                    blink_next = blink;
                end
            end
            SET_MIN: begin
                if (mode_edge) begin
                    state_next = RUN;
                end else if (tick) begin
                    blink_next = ~blink;
                end else begin
                    blink_next = blink;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Clearing the button history in reset means a button held through
    // reset release still yields one edge on the first active cycle.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state  <= RUN;
            blink  <= 1'b0;
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
        end else begin
            state  <= state_next;
            blink  <= blink_next;
            mode_q <= btn_mode;
            inc_q  <= btn_inc;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Self-checking bench for time_set_ctrl. Every driven cycle advances a
// behavioural clock model (plain integer hours/minutes/seconds) and pushes the
// expected outputs into a queue; a monitor pops one entry after every rising
// edge and compares it against the DUT. A handful of directed checkpoints also
// compare against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] hr_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [1:0] mode;
    logic       blink;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [1:0] md;
        logic       bl;
    } exp_t;

    exp_t expQ[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, mode 0 run / 1 hours / 2 minutes.
    int mHr;
    int mMin;
    int mSec;
    int mMode;
    bit mBlink;
    bit mPrevMode;
    bit mPrevInc;

    time_set_ctrl #(
        .RESET_HR  (8'h12),
        .RESET_MIN (8'h00)
    ) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .tick     (tick),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hr_bcd   (hr_bcd),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] toBcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of clock behaviour, written directly from the user-level rules.
    task automatic modelStep(input bit bm, input bit bi, input bit tk, input bit rn);
        bit modeEdge;
        bit incEdge;
        if (!rn) begin
            mHr = 12; mMin = 0; mSec = 0; mMode = 0;
            mBlink = 1'b0; mPrevMode = 1'b0; mPrevInc = 1'b0;
            return;
        end
        modeEdge  = bm && !mPrevMode;
        incEdge   = bi && !mPrevInc;
        mPrevMode = bm;
        mPrevInc  = bi;
        if (mMode == 0) begin
            if (tk) begin
                mSec++;
                if (mSec == 60) begin
                    mSec = 0;
                    mMin++;
                    if (mMin == 60) begin
                        mMin = 0;
                        mHr = (mHr + 1) % 24;
                    end
                end
            end
            if (modeEdge) begin
                mMode = 1;
                mBlink = 1'b0;
            end
        end else if (mMode == 1) begin
            if (modeEdge) begin
                mMode = 2;
                mBlink = 1'b0;
            end else begin
                if (incEdge) mHr = (mHr + 1) % 24;
                if (tk) mBlink = !mBlink;
            end
        end else begin
            if (modeEdge) begin
                mMode = 0;
                mSec = 0;
                mBlink = 1'b0;
            end else begin
                if (incEdge) mMin = (mMin + 1) % 60;
                if (tk) mBlink = !mBlink;
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected
    // outputs for the rising edge that follows.
    task automatic applyStimulus(input bit bm, input bit bi, input bit tk, input bit rn);
        exp_t e;
        @(negedge clk_in);
        btn_mode = bm;
        btn_inc  = bi;
        tick     = tk;
        reset_n  = rn;
        modelStep(bm, bi, tk, rn);
        e.hr = toBcd(mHr);
        e.mn = toBcd(mMin);
        e.sc = toBcd(mSec);
        e.md = 2'(mMode);
        e.bl = mBlink;
        expQ.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk_in);
        #2;
    endtask

    task automatic pulseMode();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pulseInc();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tickOnce();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Monitor: the DUT presents new outputs after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_hr", hr_bcd, e.hr);
                checkOutput("sb_min", min_bcd, e.mn);
                checkOutput("sb_sec", sec_bcd, e.sc);
                checkOutput("sb_mode", {6'b0, mode}, {6'b0, e.md});
                checkOutput("sb_blink", {7'b0, blink}, {7'b0, e.bl});
            end
        end
    end

    initial begin
        bit lvlMode;
        bit lvlInc;
        int guard;
        reset_n  = 1'b0;
        tick     = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("rst_hr", hr_bcd, 8'h12);
        checkOutput("rst_min", min_bcd, 8'h00);
        checkOutput("rst_sec", sec_bcd, 8'h00);
        checkOutput("rst_mode", {6'b0, mode}, 8'h00);
        checkOutput("rst_blink", {7'b0, blink}, 8'h00);

        $display("[TB] set hours");
        pulseMode();
        for (int i = 0; i < 13; i++) pulseInc();
        settle();
        checkOutput("sethr_hr", hr_bcd, 8'h01);
        checkOutput("sethr_min", min_bcd, 8'h00);
        checkOutput("sethr_mode", {6'b0, mode}, 8'h01);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("held_hr", hr_bcd, 8'h02);

        $display("[TB] set minutes");
        pulseMode();
        for (int i = 0; i < 61; i++) pulseInc();
        settle();
        checkOutput("setmin_min", min_bcd, 8'h01);
        checkOutput("setmin_hr", hr_bcd, 8'h02);
        pulseMode();
        settle();
        checkOutput("exit_mode", {6'b0, mode}, 8'h00);
        checkOutput("exit_sec", sec_bcd, 8'h00);

        $display("[TB] full rollover");
        pulseMode();
        guard = 0;
        while (mHr != 23 && guard < 30) begin pulseInc(); guard++; end
        pulseMode();
        guard = 0;
        while (mMin != 59 && guard < 70) begin pulseInc(); guard++; end
        pulseMode();
        for (int i = 0; i < 59; i++) tickOnce();
        settle();
        checkOutput("pre_roll_hr", hr_bcd, 8'h23);
        checkOutput("pre_roll_min", min_bcd, 8'h59);
        checkOutput("pre_roll_sec", sec_bcd, 8'h59);
        tickOnce();
        settle();
        checkOutput("roll_hr", hr_bcd, 8'h00);
        checkOutput("roll_min", min_bcd, 8'h00);
        checkOutput("roll_sec", sec_bcd, 8'h00);

        $display("[TB] simultaneous events");
        pulseMode();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        checkOutput("modeinc_mode", {6'b0, mode}, 8'h02);
        checkOutput("modeinc_hr", hr_bcd, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        pulseMode();
        for (int i = 0; i < 9; i++) tickOnce();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        settle();
        checkOutput("tickmode_sec", sec_bcd, 8'h10);
        checkOutput("tickmode_mode", {6'b0, mode}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] blink");
        tickOnce();
        settle();
        checkOutput("blink1", {7'b0, blink}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tickOnce();
        settle();
        checkOutput("blink2", {7'b0, blink}, 8'h00);
        tickOnce();
        settle();
        checkOutput("blink3", {7'b0, blink}, 8'h01);
        checkOutput("frozen_sec", sec_bcd, 8'h10);
        pulseMode();
        pulseInc();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        checkOutput("midrst_hr", hr_bcd, 8'h12);
        checkOutput("midrst_min", min_bcd, 8'h00);
        checkOutput("midrst_mode", {6'b0, mode}, 8'h00);

        $display("[TB] button held through reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        checkOutput("heldrst_mode", {6'b0, mode}, 8'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] random");
        lvlMode = 1'b0;
        lvlInc  = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) lvlMode = !lvlMode;
            if ($urandom_range(0, 2) == 0) lvlInc = !lvlInc;
            applyStimulus(lvlMode, lvlInc, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 299) != 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d expected=0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
